// File: rtl/uram_pkg.sv
// Shared geometry helpers and the pack-row record for the packed URAM buffer
// and the systolic-array feeder blocks.
package uram_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4096;
  localparam int DEF_PACKS = 8;

  // Lane-index width for a row of 'packs' elements (packs is a power of two).
  function automatic int lg_of(input int packs);
    return $clog2(packs);
  endfunction

  // Number of memory rows for a given element capacity.
  function automatic int rows_of(input int depth, input int packs);
    return depth / packs;
  endfunction

  localparam int DEF_ROW_W = $clog2(DEF_DEPTH / DEF_PACKS);

  // One packed row as exchanged with the feeders at the default geometry.
  typedef struct packed {
    logic [DEF_ROW_W-1:0]                 row;
    logic [DEF_PACKS-1:0][DEF_WIDTH-1:0]  data;
    logic [DEF_PACKS-1:0]                 mask;
  } pack_row_t;

endpackage

// File: rtl/uram_pack_wr.sv
// Write-side packer: gathers elements into a row buffer by lane and hands
// completed, flushed or displaced rows to a one-deep commit register.
module uram_pack_wr
  import uram_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4096,
  parameter int PACKS = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [$clog2(DEPTH)-1:0]      wr_addr,
  input  logic [WIDTH-1:0]              wr_data,
  input  logic                          wr_flush,
  output logic                          wr_pending,
  output logic                          commit_valid,
  output logic [$clog2(DEPTH)-lg_of(PACKS)-1:0] commit_row,
  output logic [PACKS*WIDTH-1:0]        commit_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int LG = lg_of(PACKS);
  localparam int RW = AW - LG;
  localparam logic [LG-1:0] LAST_LANE = LG'(PACKS - 1);

  typedef logic [PACKS-1:0][WIDTH-1:0] row_t;

  // Lanes that were never written go to memory as zero.
  function automatic row_t masked(input row_t data, input logic [PACKS-1:0] mask);
    row_t res;
    res = '0;
    for (int i = 0; i < PACKS; i++) begin
      if (mask[i]) res[i] = data[i];
    end
    return res;
  endfunction

  logic [RW-1:0]    pend_row_q, pend_row_d;
  row_t             pend_data_q, pend_data_d;
  logic [PACKS-1:0] pend_mask_q, pend_mask_d;
  logic             defer_q, defer_d;
  logic             commit_valid_q, commit_valid_d;
  logic [RW-1:0]    commit_row_q, commit_row_d;
  row_t             commit_data_q, commit_data_d;

  logic [RW-1:0] in_row;
  logic [LG-1:0] in_lane;
  logic          flush_eff;
  logic          last_lane;
  logic          row_change;

  assign in_row     = wr_addr[AW-1:LG];
  assign in_lane    = wr_addr[LG-1:0];
  // A trigger that lost the commit slot to a row change is replayed as a flush.
  assign flush_eff  = wr_flush | defer_q;
  assign last_lane  = (in_lane == LAST_LANE);
  assign row_change = wr_en && (pend_mask_q != '0) && (in_row != pend_row_q);

  // Pack-buffer update and commit selection; at most one commit per cycle.
  always_comb begin
    pend_row_d     = pend_row_q;
    pend_data_d    = pend_data_q;
    pend_mask_d    = pend_mask_q;
    defer_d        = 1'b0;
    commit_valid_d = 1'b0;
    commit_row_d   = commit_row_q;
    commit_data_d  = commit_data_q;
    if (row_change) begin
      commit_valid_d       = 1'b1;
      commit_row_d         = pend_row_q;
      commit_data_d        = masked(pend_data_q, pend_mask_q);
      pend_row_d           = in_row;
      pend_data_d[in_lane] = wr_data;
      pend_mask_d          = '0;
      pend_mask_d[in_lane] = 1'b1;
      defer_d              = last_lane | flush_eff;
    end else begin
      if (wr_en) begin
        pend_row_d           = in_row;
        pend_data_d[in_lane] = wr_data;
        pend_mask_d[in_lane] = 1'b1;
      end
      if ((wr_en && last_lane) || (flush_eff && (pend_mask_d != '0))) begin
        commit_valid_d = 1'b1;
        commit_row_d   = pend_row_d;
        commit_data_d  = masked(pend_data_d, pend_mask_d);
        pend_mask_d    = '0;
      end
    end
  end

  // Pack buffer and commit register; reset drops anything not yet in memory.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_row_q     <= '0;
      pend_data_q    <= '0;
      pend_mask_q    <= '0;
      defer_q        <= 1'b0;
      commit_valid_q <= 1'b0;
      commit_row_q   <= '0;
      commit_data_q  <= '0;
    end else begin
      pend_row_q     <= pend_row_d;
      pend_data_q    <= pend_data_d;
      pend_mask_q    <= pend_mask_d;
      defer_q        <= defer_d;
      commit_valid_q <= commit_valid_d;
      commit_row_q   <= commit_row_d;
      commit_data_q  <= commit_data_d;
    end
  end

  assign wr_pending   = (pend_mask_q != '0);
  assign commit_valid = commit_valid_q;
  assign commit_row   = commit_row_q;
  assign commit_data  = commit_data_q;

endmodule

// File: rtl/uram_pack_rw.sv
// Packed UltraRAM buffer: element-granular writes packed into rows, and a
// two-stage registered element read with a valid strobe.
module uram_pack_rw
  import uram_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4096,
  parameter int PACKS = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     wr_flush,
  output logic                     wr_pending,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid
);

  localparam int AW   = $clog2(DEPTH);
  localparam int LG   = lg_of(PACKS);
  localparam int ROWS = rows_of(DEPTH, PACKS);
  localparam int RW   = AW - LG;

  logic                   commit_valid;
  logic [RW-1:0]          commit_row;
  logic [PACKS*WIDTH-1:0] commit_data;

  uram_pack_wr #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PACKS (PACKS)
  ) u_wr (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_flush     (wr_flush),
    .wr_pending   (wr_pending),
    .commit_valid (commit_valid),
    .commit_row   (commit_row),
    .commit_data  (commit_data)
  );

  (* ram_style = "ultra" *) logic [PACKS*WIDTH-1:0] mem [ROWS];

`ifndef SYNTHESIS
  // Simulation-only zero fill so unwritten rows read back as 0.
  initial begin
    for (int i = 0; i < ROWS; i++) mem[i] = '0;
  end
`endif

  logic [PACKS*WIDTH-1:0] rd_word_q;
  logic [LG-1:0]          rd_lane_q, rd_lane_d;
  logic                   rd_v1_q, rd_v1_d;
  logic                   rd_valid_q, rd_valid_d;
  logic [WIDTH-1:0]       rd_data_q, rd_data_d;

  // Memory array: commit-register write and read-first row fetch, not reset.
  always_ff @(posedge clk) begin
    if (commit_valid) mem[commit_row] <= commit_data;
    if (rd_en) rd_word_q <= mem[rd_addr[AW-1:LG]];
  end

  // Read pipeline next-state: lane select in stage 2, output held when idle.
  always_comb begin
    rd_lane_d  = rd_lane_q;
    rd_v1_d    = rd_en;
    rd_valid_d = rd_v1_q;
    rd_data_d  = rd_data_q;
    if (rd_en) rd_lane_d = rd_addr[LG-1:0];
    if (rd_v1_q) rd_data_d = rd_word_q[rd_lane_q*WIDTH +: WIDTH];
  end

  // Read pipeline control and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_lane_q  <= '0;
      rd_v1_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_lane_q  <= rd_lane_d;
      rd_v1_q    <= rd_v1_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

endmodule
